spi_readback_controller: RTL and testbench

Return path of the SPI host link. It decodes read-request frames arriving on the SPI receive byte stream and fetches 16-bit words from the token or weight BRAM read port. The words go out MSB-first as a byte stream to the SPI slave transmit shifter. It sits beside the existing SPI write-command path, sharing the same received-byte stream, and lets the host verify loaded tokens and weights.

---
 rtl/spi_link_pkg.sv | 34 +++
 rtl/spi_readback_controller.sv | 198 +++++++++++++++++++
 tb/tb_spi_readback_controller.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_link_pkg.sv
// rtl/spi_link_pkg.sv - shared SPI host-link definitions
//
// Shared by the SPI write-command path and the readback path: FSM state
// encoding, command byte values and a small command-decode helper.
// No ports (package).

package spi_link_pkg;

  // Frame-parsing and readback states. S_CSUM is only reachable when the
  // readback checksum byte is built in.
  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_ADDR_H  = 4'd1,
    S_ADDR_L  = 4'd2,
    S_LEN     = 4'd3,
    S_RD_REQ  = 4'd4,
    S_RD_WAIT = 4'd5,
    S_SEND_H  = 4'd6,
    S_SEND_L  = 4'd7,
    S_CSUM    = 4'd8,
    S_DONE    = 4'd9
  } link_state_t;

  localparam logic [7:0] CMD_WR_TOKEN  = 8'h01;
  localparam logic [7:0] CMD_WR_WEIGHT = 8'h02;
  localparam logic [7:0] CMD_RD_TOKEN  = 8'h81;
  localparam logic [7:0] CMD_RD_WEIGHT = 8'h82;

  // True for the two read-request command bytes.
  function automatic logic is_read_cmd(input logic [7:0] b);
    return (b == CMD_RD_TOKEN) || (b == CMD_RD_WEIGHT);
  endfunction

endpackage

// File: rtl/spi_readback_controller.sv
// rtl/spi_readback_controller.sv - SPI read-request decoder and BRAM readback byte streamer
//
// Parses CMD, ADDR_H, ADDR_L, LEN frames from the SPI receive byte stream,
// reads LEN 16-bit words from the token (CMD 0x81) or weight (CMD 0x82)
// BRAM and streams them MSB-first to the SPI transmit shifter.
// Optional build macro: READBACK_CHECKSUM_EN appends one XOR byte of all
// data bytes after the final word.
//
// Ports:
//   clk, rst_n         system clock, asynchronous active-low reset
//   frame_start        chip-select pulse; aborts any frame in progress
//   spi_data           received byte, qualified by spi_byte_ready
//   spi_byte_ready     one-cycle strobe for spi_data
//   rd_en              BRAM read strobe, one per word
//   rd_sel             0 = token BRAM, 1 = weight BRAM
//   rd_addr            BRAM word address
//   rd_data            BRAM read data, valid one cycle after rd_en
//   tx_data, tx_valid  byte stream to the transmit shifter
//   tx_ready           shifter accepts when tx_valid && tx_ready
//   busy               high from accepted command until final byte handed off

module spi_readback_controller
  import spi_link_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_start,
  input  logic [7:0]            spi_data,
  input  logic                  spi_byte_ready,
  output logic                  rd_en,
  output logic                  rd_sel,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy
);

  // One extra bit so that LEN = 0 can be held as the full 2^LEN_WIDTH words.
  localparam int CNT_W = LEN_WIDTH + 1;

  link_state_t           state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CNT_W-1:0]      count_q;
  logic [7:0]            word_lo;
`ifdef READBACK_CHECKSUM_EN
  logic [7:0]            csum_q;
`endif

  logic tx_fire;
  assign tx_fire = tx_valid && tx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      rd_en    <= 1'b0;
      rd_sel   <= 1'b0;
      rd_addr  <= '0;
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      addr_q   <= '0;
      count_q  <= '0;
      word_lo  <= 8'h00;
`ifdef READBACK_CHECKSUM_EN
      csum_q   <= 8'h00;
`endif
    end else if (frame_start) begin
      // Chip-select edge wins over everything, including a byte strobe in
      // the same cycle; that byte is dropped rather than parsed as CMD.
      state    <= S_IDLE;
      rd_en    <= 1'b0;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
    end else begin
      // rd_en is only raised on the transition into S_RD_REQ.
      rd_en <= 1'b0;

      case (state)
        S_IDLE: begin
          if (spi_byte_ready && is_read_cmd(spi_data)) begin
            rd_sel <= spi_data[1];
`ifdef READBACK_CHECKSUM_EN
            csum_q <= 8'h00;
`endif
            state  <= S_ADDR_H;
          end
        end

        S_ADDR_H: begin
          if (spi_byte_ready) begin
            addr_q <= ADDR_WIDTH'(spi_data);
            state  <= S_ADDR_L;
          end
        end

        S_ADDR_L: begin
          // Address bits above ADDR_WIDTH fall off in the truncating cast.
          if (spi_byte_ready) begin
            addr_q <= ADDR_WIDTH'({addr_q, spi_data});
            state  <= S_LEN;
          end
        end

        S_LEN: begin
          if (spi_byte_ready) begin
            if (spi_data[LEN_WIDTH-1:0] == '0) begin
              count_q <= CNT_W'(1) << LEN_WIDTH;
            end else begin
              count_q <= CNT_W'(spi_data[LEN_WIDTH-1:0]);
            end
            busy    <= 1'b1;
            rd_en   <= 1'b1;
            rd_addr <= addr_q;
            state   <= S_RD_REQ;
          end
        end

        S_RD_REQ: begin
          state <= S_RD_WAIT;
        end

        S_RD_WAIT: begin
          // High byte goes straight to the transmit register; only the low
          // byte needs holding for the second transfer.
          tx_data  <= rd_data[15:8];
          word_lo  <= rd_data[7:0];
          tx_valid <= 1'b1;
          state    <= S_SEND_H;
        end

        S_SEND_H: begin
          if (tx_fire) begin
`ifdef READBACK_CHECKSUM_EN
            csum_q  <= csum_q ^ tx_data;
`endif
            tx_data <= word_lo;
            state   <= S_SEND_L;
          end
        end

        S_SEND_L: begin
          if (tx_fire) begin
            count_q <= count_q - CNT_W'(1);
            addr_q  <= addr_q + ADDR_WIDTH'(1);
`ifdef READBACK_CHECKSUM_EN
            csum_q  <= csum_q ^ tx_data;
`endif
            if (count_q == CNT_W'(1)) begin
`ifdef READBACK_CHECKSUM_EN
              // tx_valid stays high: the checksum byte follows immediately.
              tx_data <= csum_q ^ tx_data;
              state   <= S_CSUM;
`else
              tx_valid <= 1'b0;
              busy     <= 1'b0;
              state    <= S_DONE;
`endif
            end else begin
              tx_valid <= 1'b0;
              rd_en    <= 1'b1;
              rd_addr  <= addr_q + ADDR_WIDTH'(1);
              state    <= S_RD_REQ;
            end
          end
        end

`ifdef READBACK_CHECKSUM_EN
        S_CSUM: begin
          if (tx_fire) begin
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            state    <= S_DONE;
          end
        end
`endif

        S_DONE: begin
          tx_valid <= 1'b0;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end

        default: begin
          tx_valid <= 1'b0;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_readback_controller.sv
// tb/tb_spi_readback_controller.sv - directed self-checking bench for spi_readback_controller

module tb_spi_readback_controller;

`ifdef READBACK_CHECKSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic [7:0]  spi_data = 8'h00;
  logic        spi_byte_ready = 1'b0;
  logic        rd_en;
  logic        rd_sel;
  logic [9:0]  rd_addr;
  logic [15:0] rd_data = 16'h0000;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [15:0] token_mem  [0:1023];
  logic [15:0] weight_mem [0:1023];

  logic [7:0]  rx_q[$];
  logic [7:0]  exp_q[$];
  logic [10:0] rd_q[$];

  bit          stall_mode = 1'b0;
  int          phase = 0;
  bit          stall_pend = 1'b0;
  logic [7:0]  stall_data = 8'h00;
  int          stall_seen = 0;
  int          stall_viol = 0;

  spi_readback_controller #(
    .ADDR_WIDTH(10),
    .DATA_WIDTH(16),
    .LEN_WIDTH (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame_start   (frame_start),
    .spi_data      (spi_data),
    .spi_byte_ready(spi_byte_ready),
    .rd_en         (rd_en),
    .rd_sel        (rd_sel),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // BRAM model: data valid the cycle after rd_en.
  always @(posedge clk) begin
    if (rd_en) rd_data <= rd_sel ? weight_mem[rd_addr] : token_mem[rd_addr];
  end

  // Transmitter ready: always ready, or low 3 cycles out of every 4.
  always @(posedge clk) begin
    #1;
    if (stall_mode) begin
      tx_ready = (phase == 3);
      phase = (phase + 1) % 4;
    end else begin
      tx_ready = 1'b1;
    end
  end

  // Monitors sample away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_valid && tx_ready) rx_q.push_back(tx_data);
      if (rd_en) rd_q.push_back({rd_sel, rd_addr});
      if (stall_pend) begin
        stall_seen++;
        if (!tx_valid || tx_data != stall_data) stall_viol++;
      end
      stall_pend = tx_valid && !tx_ready;
      stall_data = tx_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    spi_data = b;
    spi_byte_ready = 1'b1;
    @(posedge clk); #1;
    spi_byte_ready = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] ah,
                            input logic [7:0] al, input logic [7:0] len);
    send_byte(c);
    send_byte(ah);
    send_byte(al);
    send_byte(len);
  endtask

  task automatic wait_bytes(input string tag, input int n);
    int cyc;
    cyc = 0;
    while (rx_q.size() < n && cyc < 300) begin
      @(negedge clk); #1;
      cyc++;
    end
    if (rx_q.size() < n) check({tag, "_timeout"}, rx_q.size(), n);
  endtask

  task automatic wait_idle(input string tag);
    int cyc;
    cyc = 0;
    while (busy && cyc < 300) begin
      @(negedge clk); #1;
      cyc++;
    end
    if (busy) check({tag, "_busy_timeout"}, busy, 1'b0);
  endtask

  task automatic clear_q();
    rx_q.delete();
    exp_q.delete();
    rd_q.delete();
  endtask

  task automatic expect_rx(input string tag, input bit add_csum);
    logic [7:0] x;
    x = 8'h00;
    foreach (exp_q[i]) x ^= exp_q[i];
    if (add_csum && CSUM_ON) exp_q.push_back(x);
    check({tag, "_count"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), rx_q[i], exp_q[i]);
  endtask

  initial begin
    int lat;
    for (int i = 0; i < 1024; i++) begin
      token_mem[i]  = 16'h0000;
      weight_mem[i] = 16'h0000;
    end
    token_mem[10'h010]  = 16'h1234;
    token_mem[10'h011]  = 16'h5678;
    weight_mem[10'h3FF] = 16'h03E8;
    weight_mem[10'h000] = 16'hBEEF;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd_en",    rd_en,    1'b0);
    check("rst_rd_sel",   rd_sel,   1'b0);
    check("rst_rd_addr",  rd_addr,  10'h000);
    check("rst_tx_data",  tx_data,  8'h00);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_busy",     busy,     1'b0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Token read of two words, latency from LEN capture to first tx_valid
    clear_q();
    send_frame(8'h81, 8'h00, 8'h10, 8'h02);
    lat = 0;
    while (!tx_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("tok_latency", lat, 3);
    check("tok_busy_during", busy, 1'b1);
    wait_bytes("tok", 4 + int'(CSUM_ON));
    @(negedge clk);
    check("tok_busy_after", busy, 1'b0);
    check("tok_valid_after", tx_valid, 1'b0);
    exp_q = '{8'h12, 8'h34, 8'h56, 8'h78};
    expect_rx("tok", 1'b1);
    check("tok_rd_count", rd_q.size(), 2);
    if (rd_q.size() >= 2) begin
      check("tok_rd0", rd_q[0], 11'h010);
      check("tok_rd1", rd_q[1], 11'h011);
    end
    repeat (3) @(posedge clk);

    // Weight read with address wrap 0x3FF -> 0x000
    clear_q();
    send_frame(8'h82, 8'h03, 8'hFF, 8'h02);
    wait_bytes("wgt", 4 + int'(CSUM_ON));
    wait_idle("wgt");
    exp_q = '{8'h03, 8'hE8, 8'hBE, 8'hEF};
    expect_rx("wgt", 1'b1);
    check("wgt_rd_count", rd_q.size(), 2);
    if (rd_q.size() >= 2) begin
      check("wgt_rd0", rd_q[0], 11'h7FF);
      check("wgt_rd1", rd_q[1], 11'h400);
    end
    repeat (3) @(posedge clk);

    // Backpressure: tx_ready low 3 of every 4 cycles
    clear_q();
    stall_seen = 0;
    stall_viol = 0;
    stall_mode = 1'b1;
    send_frame(8'h81, 8'h00, 8'h10, 8'h01);
    wait_bytes("stall", 2 + int'(CSUM_ON));
    wait_idle("stall");
    @(posedge clk); #1;
    stall_mode = 1'b0;
    check("stall_hold_violations", stall_viol, 0);
    check("stall_exercised", stall_seen != 0, 1'b1);
    exp_q = '{8'h12, 8'h34};
    expect_rx("stall", 1'b1);
    repeat (3) @(posedge clk);

    // Abort with frame_start after the second byte
    clear_q();
    send_frame(8'h81, 8'h00, 8'h10, 8'h05);
    wait_bytes("abort", 2);
    @(posedge clk); #1;
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    @(negedge clk);
    check("abort_valid", tx_valid, 1'b0);
    check("abort_busy",  busy,     1'b0);
    repeat (6) @(posedge clk);
    exp_q = '{8'h12, 8'h34};
    expect_rx("abort", 1'b0);
    clear_q();
    send_frame(8'h81, 8'h00, 8'h11, 8'h01);
    wait_bytes("post_abort", 2 + int'(CSUM_ON));
    wait_idle("post_abort");
    exp_q = '{8'h56, 8'h78};
    expect_rx("post_abort", 1'b1);
    repeat (3) @(posedge clk);

    // frame_start beats a simultaneous command byte
    clear_q();
    @(posedge clk); #1;
    frame_start = 1'b1;
    spi_byte_ready = 1'b1;
    spi_data = 8'h81;
    @(posedge clk); #1;
    frame_start = 1'b0;
    spi_byte_ready = 1'b0;
    send_byte(8'h00);
    send_byte(8'h10);
    send_byte(8'h01);
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("prio_busy", busy, 1'b0);
    check("prio_rx_count", rx_q.size(), 0);

    // Non-command byte ignored, dummy bytes while busy ignored
    clear_q();
    send_byte(8'h7F);
    send_frame(8'h81, 8'h00, 8'h10, 8'h01);
    send_byte(8'h81);
    send_byte(8'hFF);
    wait_bytes("dummy", 2 + int'(CSUM_ON));
    wait_idle("dummy");
    repeat (6) @(posedge clk);
    exp_q = '{8'h12, 8'h34};
    expect_rx("dummy", 1'b1);
    check("dummy_rd_count", rd_q.size(), 1);
    check("dummy_idle_busy", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
